// File: rtl/restoring_divider_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Results and div_by_zero are registered on leaving DONE and held until the next one.
module restoring_divider_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH:0]   part_r;
    logic [CW-1:0]    cnt;
    logic             zero_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             last_step;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] r_nxt;

    // Trial MSB doubles as the sign since |shifted - divisor| < 2**WIDTH
    assign shifted   = (part_r << 1) | {{WIDTH{1'b0}}, dvd_r[WIDTH-1]};
    assign trial     = shifted - {1'b0, dsr_r};
    assign last_step = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        q_nxt = zero_r ? '1 : quo_r;
        r_nxt = zero_r ? dvd_r : part_r[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_r  <= '0;
            dsr_r  <= '0;
            quo_r  <= '0;
            part_r <= '0;
            cnt    <= '0;
            zero_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd_r  <= dividend;
                        dsr_r  <= divisor;
                        zero_r <= (divisor == '0);
                        quo_r  <= '0;
                        part_r <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    dvd_r  <= dvd_r << 1;
                    part_r <= trial[WIDTH] ? shifted : trial;
                    quo_r  <= (quo_r << 1) | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                quotient    <= q_nxt;
                remainder   <= r_nxt;
                div_by_zero <= zero_r;
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Scoreboard bench for restoring_divider_seq: driver pushes model results,
// a negedge monitor pops them on every done pulse.
module tb_restoring_divider_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    restoring_divider_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    int           ncyc = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_z = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b));
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : W'(int'(a) % int'(b));
    endfunction

    // Monitor: every done must match the oldest pending result at its latency
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            last_q = '0;
            last_r = '0;
            last_z = 1'b0;
        end else if (done) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", done, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("quotient", quotient, mon_e.q);
                chk("remainder", remainder, mon_e.r);
                chk("div_by_zero", div_by_zero, mon_e.z);
                chk("latency", ncyc - mon_e.acc - 1, mon_e.lat);
                chk("busy_at_done", busy, 0);
                last_q = mon_e.q;
                last_r = mon_e.r;
                last_z = mon_e.z;
            end
        end else begin
            chk("hold_quotient", quotient, last_q);
            chk("hold_remainder", remainder, last_r);
            chk("hold_dbz", div_by_zero, last_z);
        end
    end

    // Called just after a negedge with the DUT idle; returns just after a negedge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit junk, input logic [W-1:0] ja,
                         input logic [W-1:0] jb, input bit push);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.q   = ref_q(a, b);
            e.r   = ref_r(a, b);
            e.z   = (b == 0);
            e.acc = ncyc;
            e.lat = (b == 0) ? 1 : W + 1;
            sbq.push_back(e);
        end
        dividend = ja;
        divisor  = jb;
        start    = junk;
        if (junk) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", done, 1);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        issue(a, b, 1'b0, W'($urandom), W'($urandom), 1'b1);
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        op(4'd10, 4'd6);
        op(4'd15, 4'd1);
        op(4'd3, 4'd7);
        op(4'd0, 4'd5);
        op(4'd9, 4'd0);
        op(4'd12, 4'd4);

        // start while busy must be ignored
        issue(4'd10, 4'd6, 1'b1, 4'd15, 4'd3, 1'b1);
        wait_done();
        repeat (8) @(negedge clk);

        // reset in the second CALC cycle aborts with no done
        issue(4'd14, 4'd3, 1'b0, 4'd0, 4'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        op(4'd14, 4'd3);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op(W'(a), W'(b));
            end
        end

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            issue(ra, rb, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b1);
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        chk("pending_results", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/restoring_divider_seq.md
RESTORING_DIVIDER_SEQ -- requirements
Module: restoring_divider_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits (legal values 2..16).
REQ-002 SHALL have port: clk  input  1  rising-edge clock; sole clock domain.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: dividend  input  WIDTH  unsigned numerator; captured when start is accepted.
REQ-006 SHALL have port: divisor  input  WIDTH  unsigned denominator; captured when start is accepted.
REQ-007 SHALL have port: busy  output  1  high in CALC and DONE states.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port: quotient  output  WIDTH  registered result.
REQ-010 SHALL have port: remainder  output  WIDTH  registered result.
REQ-011 SHALL have port: div_by_zero  output  1  registered flag; set with done when captured divisor==0.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: start=1 -> capture operands and clear the step counter; go to CALC if divisor!=0, else DONE.
REQ-014 IDLE: start=0 -> stay in IDLE; outputs hold.
REQ-015 CALC SHALL perform one restoring step per cycle: shift the (WIDTH+1)-bit partial remainder left, inserting the next dividend bit (MSB first), then trial = partial - {0,divisor}.
REQ-016 The step SHALL use trial MSB as the sign: trial MSB=0 -> partial=trial and quotient bit=1; else partial unchanged and quotient bit=0.
REQ-017 CALC SHALL execute exactly WIDTH steps, then go to DONE.
REQ-018 DONE SHALL last exactly one cycle, drive done=1 and update quotient/remainder/div_by_zero, then go to IDLE.
REQ-019 Latency SHALL be WIDTH+1 cycles from the accepting edge to done high (divisor!=0) and 1 cycle for divisor==0.
REQ-020 Divide by zero SHALL yield quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-021 Normal completion SHALL clear div_by_zero.
REQ-022 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every nonzero divisor.
REQ-023 start while busy=1 SHALL be ignored; captured operands remain unchanged.
REQ-024 Operand input changes after acceptance SHALL not affect the result.
REQ-025 quotient, remainder and div_by_zero SHALL hold their last values until the next DONE.
REQ-026 start high in the cycle after DONE (IDLE) SHALL be accepted, allowing back-to-back operations with one idle cycle between them.

Reset
REQ-027 rst=1 SHALL force IDLE and clear the step counter, the partial remainder, busy, done, quotient, remainder and div_by_zero to 0 on the same clock edge.
REQ-028 rst SHALL take priority over start and all state transitions.
REQ-029 rst asserted mid-CALC SHALL abort the operation with no done pulse.
REQ-030 The first start accepted after rst deasserts SHALL behave normally.

Verification (WIDTH=4)
REQ-031 dividend=4'b1010, divisor=4'b0110, start one cycle -> done 5 cycles later; quotient=1, remainder=4, div_by_zero=0.
REQ-032 15/1 -> quotient=15, remainder=0; 3/7 -> quotient=0, remainder=3; 0/5 -> quotient=0, remainder=0.
REQ-033 9/0 -> done 1 cycle after accept; quotient=4'b1111, remainder=9, div_by_zero=1; next 12/4 -> quotient=3, remainder=0, div_by_zero=0.
REQ-034 Start 10/6, then pulse start with 15/3 while busy -> single done with quotient=1, remainder=4; no second done.
REQ-035 Start 14/3, assert rst at the 2nd CALC cycle -> busy=0, done never pulses, outputs=0; then 14/3 -> quotient=4, remainder=2.
REQ-036 Exhaustive: all 256 operand pairs -> REQ-020/REQ-022 hold and each done arrives at the REQ-019 latency.
